// File: rtl/mdu_seq_ctrl.sv
// Iterative multiply/divide sequencer for the M extension.
// Shift-add multiply and restoring divide, one bit per cycle.
module mdu_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             is_32bit,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] LO32  = {{(WIDTH-32){1'b0}}, {32{1'b1}}};
    localparam logic [WIDTH-1:0] MIN32 = {{(WIDTH-32){1'b0}}, 1'b1, 31'b0};
    localparam logic [WIDTH-1:0] MINW  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {K_MUL, K_QUO, K_REM} kind_t;

    state_t state, state_nxt;
    kind_t kind;
    logic neg, w32;
    logic [CW-1:0] cnt, n_load;
    logic [WIDTH-1:0] acc, sh, dsr;

    logic is_mul, is_div, is_divu, is_rem, is_remu;
    logic sgn_op, any_div, neg_a, neg_b;
    logic div_zero, ovf, special, accept;
    logic [WIDTH-1:0] mask, a, b, mag_a, mag_b, spec_r;
    logic [WIDTH-1:0] nxt_acc, nxt_sh, nxt_dsr, raw, fin;
    logic [WIDTH:0] rs;

    // 32-bit ops always deliver a result sign-extended from bit 31
    function automatic logic [WIDTH-1:0] fit(
        input logic [WIDTH-1:0] v,
        input logic w
    );
        fit = w ? {{(WIDTH-32){v[31]}}, v[31:0]} : v;
    endfunction

    // priority decode so a malformed op still picks exactly one operation
    assign is_mul  = op[0];
    assign is_div  = ~op[0] & op[1];
    assign is_divu = ~|op[1:0] & op[2];
    assign is_rem  = ~|op[2:0] & op[3];
    assign is_remu = ~|op[3:0] & op[4];

    assign in_ready  = (state == IDLE) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // operand magnitudes and the results that need no iteration
    always_comb begin
        mask     = is_32bit ? LO32 : '1;
        a        = src1 & mask;
        b        = src2 & mask;
        sgn_op   = is_div | is_rem;
        any_div  = is_div | is_divu | is_rem | is_remu;
        neg_a    = sgn_op & (is_32bit ? src1[31] : src1[WIDTH-1]);
        neg_b    = sgn_op & (is_32bit ? src2[31] : src2[WIDTH-1]);
        mag_a    = neg_a ? ((-a) & mask) : a;
        mag_b    = neg_b ? ((-b) & mask) : b;
        div_zero = any_div && (b == '0);
        ovf      = sgn_op && (a == (is_32bit ? MIN32 : MINW)) && (b == mask);
        special  = (op == 5'd0) | div_zero | ovf;
        n_load   = is_32bit ? CW'(32) : CW'(WIDTH);
        spec_r   = '0;
        if (div_zero)
            spec_r = (is_div | is_divu) ? mask : a;
        else if (ovf)
            spec_r = is_div ? a : '0;
        spec_r = fit(spec_r, is_32bit);
    end

    // one multiply or divide step, plus the sign-corrected final value
    always_comb begin
        nxt_acc = acc;
        nxt_sh  = sh;
        nxt_dsr = dsr;
        rs      = {acc, sh[WIDTH-1]};
        if (kind == K_MUL) begin
            nxt_acc = acc + (sh[0] ? dsr : '0);
            nxt_sh  = sh >> 1;
            nxt_dsr = dsr << 1;
        end else if (rs >= {1'b0, dsr}) begin
            nxt_acc = WIDTH'(rs - {1'b0, dsr});
            nxt_sh  = {sh[WIDTH-2:0], 1'b1};
        end else begin
            nxt_acc = rs[WIDTH-1:0];
            nxt_sh  = {sh[WIDTH-2:0], 1'b0};
        end
        raw = (kind == K_QUO) ? nxt_sh : nxt_acc;
        fin = fit(neg ? -raw : raw, w32);
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic; flush overrides everything but reset
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = special ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    // operand capture, iteration registers, counter and result
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            result <= '0;
            acc    <= '0;
            sh     <= '0;
            dsr    <= '0;
            kind   <= K_MUL;
            neg    <= 1'b0;
            w32    <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (accept) begin
            cnt  <= n_load;
            w32  <= is_32bit;
            acc  <= '0;
            kind <= is_mul ? K_MUL : ((is_div | is_divu) ? K_QUO : K_REM);
            neg  <= (is_div & (neg_a ^ neg_b)) | (is_rem & neg_a);
            if (is_mul) begin
                sh  <= b;
                dsr <= a;
            end else begin
                sh  <= is_32bit ? (mag_a << (WIDTH - 32)) : mag_a;
                dsr <= mag_b;
            end
            if (special)
                result <= spec_r;
        end else if (state == CALC) begin
            acc <= nxt_acc;
            sh  <= nxt_sh;
            dsr <= nxt_dsr;
            if (cnt != '0)
                cnt <= cnt - CW'(1);
            if (cnt == CW'(1))
                result <= fin;
        end
    end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Testbench for mdu_seq_ctrl: directed vectors, random ops against
// an arithmetic reference, backpressure, flush and reset.
module tb_mdu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = 5'd0;
    logic        is_32bit = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq_ctrl #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_32bit(is_32bit),
        .src1(src1), .src2(src2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    // reference: RISC-V M semantics straight from the arithmetic rules
    function automatic void model(
        input logic [4:0] o, input logic w,
        input logic [63:0] a, input logic [63:0] b,
        output logic [63:0] r, output logic sp
    );
        int k;
        logic signed [63:0] x, y;
        logic signed [31:0] x32, y32;
        logic [31:0] ua, ub, r32;
        if (o[0]) k = 0;
        else if (o[1]) k = 1;
        else if (o[2]) k = 2;
        else if (o[3]) k = 3;
        else if (o[4]) k = 4;
        else k = 5;
        sp = 1'b0;
        r = '0;
        if (w) begin
            ua = a[31:0]; ub = b[31:0];
            x32 = a[31:0]; y32 = b[31:0];
            r32 = '0;
            case (k)
                0: r32 = ua * ub;
                1: if (ub == 0) begin r32 = '1; sp = 1; end
                   else if (x32 == 32'sh80000000 && y32 == -1) begin r32 = ua; sp = 1; end
                   else r32 = x32 / y32;
                2: if (ub == 0) begin r32 = '1; sp = 1; end
                   else r32 = ua / ub;
                3: if (ub == 0) begin r32 = ua; sp = 1; end
                   else if (x32 == 32'sh80000000 && y32 == -1) begin r32 = 0; sp = 1; end
                   else r32 = x32 % y32;
                4: if (ub == 0) begin r32 = ua; sp = 1; end
                   else r32 = ua % ub;
                default: begin r32 = 0; sp = 1; end
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            x = a; y = b;
            case (k)
                0: r = a * b;
                1: if (b == 0) begin r = '1; sp = 1; end
                   else if (x == 64'sh8000000000000000 && y == -1) begin r = a; sp = 1; end
                   else r = x / y;
                2: if (b == 0) begin r = '1; sp = 1; end
                   else r = a / b;
                3: if (b == 0) begin r = a; sp = 1; end
                   else if (x == 64'sh8000000000000000 && y == -1) begin r = 0; sp = 1; end
                   else r = x % y;
                4: if (b == 0) begin r = a; sp = 1; end
                   else r = a % b;
                default: begin r = 0; sp = 1; end
            endcase
        end
    endfunction

    function automatic logic [63:0] pick_val(input logic w);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        case ($urandom_range(0, 6))
            2: v = 64'($urandom_range(0, 20));
            3: v = w ? {v[63:32], 32'd0} : 64'd0;
            4: v = w ? {v[63:32], 32'hFFFF_FFFF} : '1;
            5: v = w ? {v[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
            6: v = {v[63:32], 32'($urandom_range(0, 9))};
            default: ;
        endcase
        return v;
    endfunction

    // drive one request, scramble inputs after accept, wait and consume
    task automatic run_op(
        input logic [4:0] o, input logic w,
        input logic [63:0] a, input logic [63:0] b,
        output int lat, output logic [63:0] res, output logic rdy
    );
        op = o; is_32bit = w; src1 = a; src2 = b;
        in_valid = 1'b1; out_ready = 1'b1;
        rdy = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom());
        is_32bit = 1'($urandom());
        src1 = {$urandom(), $urandom()};
        src2 = {$urandom(), $urandom()};
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b busy=%b result=%h, want 0 0 0",
                     out_valid, busy, result);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [4:0]  v_op  [12] = '{5'b00001, 5'b00001, 5'b00010, 5'b01000,
                                    5'b10000, 5'b00010, 5'b00100, 5'b00010,
                                    5'b00000, 5'b00011, 5'b00100, 5'b01000};
        logic        v_w   [12] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1};
        logic [63:0] v_a   [12] = '{64'd7, 64'h4000_0000, -64'd7, -64'd7,
                                    64'd7, 64'h8000_0000_0000_0000, 64'd12345,
                                    64'hDEAD_BEEF_8000_0000, 64'd5, 64'd6,
                                    64'h0000_0000_FFFF_FFF0, 64'h0000_0000_FFFF_FFF9};
        logic [63:0] v_b   [12] = '{-64'd3, 64'd2, 64'd2, 64'd2, 64'd0, '1,
                                    64'd0, 64'h0000_0000_FFFF_FFFF, 64'd3,
                                    64'd7, 64'd1, 64'd2};
        logic [63:0] v_r   [12] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_8000_0000,
                                    64'hFFFF_FFFF_FFFF_FFFD, '1, 64'd7,
                                    64'h8000_0000_0000_0000, '1,
                                    64'hFFFF_FFFF_8000_0000, 64'd0, 64'd42,
                                    64'hFFFF_FFFF_FFFF_FFF0, '1};
        int          v_lat [12] = '{64, 32, 64, 64, 0, 0, 0, 0, 0, 64, 32, 32};
        int lat;
        logic [63:0] res;
        logic rdy;
        for (int i = 0; i < 12; i++) begin
            run_op(v_op[i], v_w[i], v_a[i], v_b[i], lat, res, rdy);
            checks++;
            if (res !== v_r[i] || lat != v_lat[i] || rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d: result=%h lat=%0d rdy=%b, want %h %0d 1",
                         i, res, lat, rdy, v_r[i], v_lat[i]);
            end
        end
    endtask

    task automatic test_random();
        int lat, exp_lat;
        logic [63:0] res, a, b, exp_r;
        logic [4:0] o;
        logic w, sp, rdy;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: o = 5'b00001;
                1: o = 5'b00010;
                2: o = 5'b00100;
                3: o = 5'b01000;
                4: o = 5'b10000;
                5: o = 5'b00000;
                default: o = 5'($urandom());
            endcase
            w = 1'($urandom());
            a = pick_val(w);
            b = pick_val(w);
            model(o, w, a, b, exp_r, sp);
            exp_lat = sp ? 0 : (w ? 32 : 64);
            run_op(o, w, a, b, lat, res, rdy);
            checks++;
            if (res !== exp_r || lat != exp_lat || rdy !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d op=%b w=%b a=%h b=%h: result=%h lat=%0d, want %h %0d",
                         i, o, w, a, b, res, lat, exp_r, exp_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] held;
        op = 5'b00100; is_32bit = 1'b0; src1 = 64'd100; src2 = 64'd7;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (result !== 64'd14 || lat != 64) begin
            errors++;
            $display("FAIL bp_first: result=%h lat=%0d, want e 64", result, lat);
        end
        held = result;
        op = 5'b00001; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b result=%h in_ready=%b, want 1 %h 0",
                         i, out_valid, result, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_consume: out_valid=%b busy=%b in_ready=%b, want 0 0 1",
                     out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next_accept: busy=%b want 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (result !== 64'd15 || lat != 64) begin
            errors++;
            $display("FAIL bp_second: result=%h lat=%0d, want f 64", result, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic seen;
        op = 5'b00010; is_32bit = 1'b0; src1 = -64'd100; src2 = 64'd7;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; op = 5'b00001;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_result: out_valid seen=%b want 0", seen);
        end
        op = 5'b00001; src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL rst_calc: busy=%b out_valid=%b result=%h, want 0 0 0",
                     busy, out_valid, result);
        end
        rst = 1'b1; flush = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_result: seen=%b in_ready=%b, want 0 1", seen, in_ready);
        end
        out_ready = 1'b0;
        op = 5'b10000; src1 = 64'd9; src2 = 64'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 64'd9) begin
            errors++;
            $display("FAIL done_special: out_valid=%b result=%h, want 1 9", out_valid, result);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_done: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
